// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg -- shared constants and types for the I2S transmitter.
//   FRAME_BITS : bit clocks per stereo frame (left + right)
//   SLOT_BITS  : bit clocks per channel slot
//   BIT_CNT_W  : width of the frame bit counter
//   SLOT_W     : width of the slot position within a channel
//   state_e    : transmitter control states
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int SLOT_W     = $clog2(SLOT_BITS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/i2s_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_if -- sample stream handshake into the I2S transmitter.
//   sample_i : signed mono sample (width_p bits)
//   valid_i  : sample_i valid
//   ready_o  : transmitter can accept; transfer on valid_i && ready_o
// Modports: master (sample source), slave (i2s_tx).
// ---------------------------------------------------------------------------
interface i2s_tx_if #(
    parameter int width_p = 24
) ();

    logic [width_p-1:0] sample_i;
    logic               valid_i;
    logic               ready_o;

    modport master (output sample_i, output valid_i, input ready_o);
    modport slave  (input sample_i, input valid_i, output ready_o);

endinterface

// File: rtl/i2s_tx_sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo -- small synchronous FIFO holding samples awaiting transmit.
//   clk_i, reset_i : clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i : write request and data (ignored when full)
//   pop_i, data_o  : read request and head-of-queue data (ignored when empty)
//   full_o, empty_o: flags decoded from the registered occupancy
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int width_p = 24,
    parameter int depth_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int CNT_W = $clog2(depth_p + 1);

    logic [width_p-1:0] mem_q [depth_p];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok_s, pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(depth_p - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full_o    = (count_q == CNT_W'(depth_p));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; push+pop together leaves occupancy unchanged.
    always_comb begin
        wr_ptr_d = push_ok_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= {width_p{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx -- mono-to-stereo I2S transmitter (64 bclk per frame, 32 per slot).
//   clk_i, reset_i : clock, synchronous active-high reset
//   in_if (slave)  : sample_i / valid_i / ready_o stream handshake
//   bclk_o         : bit clock, period 2*bclk_div_p clk_i cycles
//   lrclk_o        : word select, 0 = left, 1 = right
//   sdata_o        : serial data, MSB one bclk after each lrclk edge
//   underflow_o    : one-cycle pulse when a frame starts with no sample
//   underflow_cnt_o: saturating underflow count, present only when the
//                    macro I2S_TX_UNDERFLOW_CNT_EN is defined
// ---------------------------------------------------------------------------
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int width_p    = 24,
    parameter int bclk_div_p = 2
) (
    input  logic    clk_i,
    input  logic    reset_i,
    i2s_tx_if.slave in_if,
    output logic    bclk_o,
    output logic    lrclk_o,
    output logic    sdata_o,
    output logic    underflow_o
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt_o
`endif
);

    localparam int DIV_W = (bclk_div_p > 1) ? $clog2(bclk_div_p) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(bclk_div_p - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 bclk_q, bclk_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic [width_p-1:0]   tx_q, tx_d;
    logic                 underflow_q, underflow_d;
    logic                 active_q;

    logic                 push_s, pop_s, full_s, empty_s, ready_s;
    logic [width_p-1:0]   fifo_data_s;
    logic [BIT_CNT_W-1:0] bit_cnt_inc_s;
    logic [SLOT_BITS-1:0] slot_word_s;
    logic [SLOT_W-1:0]    slot_idx_s;

    // active_q keeps ready low for the whole reset and releases it one edge later.
    assign ready_s      = active_q & ~full_s;
    assign in_if.ready_o = ready_s;
    assign push_s       = in_if.valid_i & ready_s;

    sample_fifo #(
        .width_p (width_p),
        .depth_p (2)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .data_i  (in_if.sample_i),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Slot word: bit 31 is slot 0 (always 0), then the sample MSB-first, zero padded.
    // Indexing with 31-p yields tx[width_p-p] for p in 1..width_p and 0 elsewhere.
    assign bit_cnt_inc_s = bit_cnt_q + BIT_CNT_W'(1);
    assign slot_word_s   = SLOT_BITS'(tx_q) << (SLOT_BITS - 1 - width_p);
    assign slot_idx_s    = SLOT_W'(SLOT_BITS - 1) - bit_cnt_inc_s[SLOT_W-1:0];

    // Control FSM next-state plus bit-clock, frame counter and serialiser updates.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bclk_d      = bclk_q;
        bit_cnt_d   = bit_cnt_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        tx_d        = tx_q;
        underflow_d = 1'b0;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d     = {DIV_W{1'b0}};
                bclk_d    = 1'b0;
                bit_cnt_d = {BIT_CNT_W{1'b0}};
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                if (!empty_s) begin
                    state_d = ST_RUN;
                    pop_s   = 1'b1;
                    tx_d    = fifo_data_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = {DIV_W{1'b0}};
                    bclk_d = ~bclk_q;
                    // bclk high -> low: advance the frame and present the next bit.
                    if (bclk_q) begin
                        bit_cnt_d = bit_cnt_inc_s;
                        lrclk_d   = bit_cnt_inc_s[BIT_CNT_W-1];
                        sdata_d   = slot_word_s[slot_idx_s];
                        if (bit_cnt_q == BIT_LAST) begin
                            if (!empty_s) begin
                                pop_s = 1'b1;
                                tx_d  = fifo_data_s;
                            end else begin
                                tx_d        = {width_p{1'b0}};
                                underflow_d = 1'b1;
                            end
                        end else begin
                            tx_d = tx_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            div_q       <= {DIV_W{1'b0}};
            bclk_q      <= 1'b0;
            bit_cnt_q   <= {BIT_CNT_W{1'b0}};
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            tx_q        <= {width_p{1'b0}};
            underflow_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            tx_q        <= tx_d;
            underflow_q <= underflow_d;
            active_q    <= 1'b1;
        end
    end

    assign bclk_o      = bclk_q;
    assign lrclk_o     = lrclk_q;
    assign sdata_o     = sdata_q;
    assign underflow_o = underflow_q;

`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q;

    // Saturating count of underflow pulses, stepped on the same edge as the pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            uf_cnt_q <= 16'h0000;
        end else if (underflow_d && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_q <= uf_cnt_q + 16'h0001;
        end else begin
            uf_cnt_q <= uf_cnt_q;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`endif

endmodule
